// File: rtl/timer_bank_pkg.sv
// Register map constants and helpers shared by timer_bank and timer_bank_channel.
package timer_bank_pkg;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COMPARE = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int unsigned CTRL_ENABLE       = 0;
    localparam int unsigned CTRL_PERIODIC     = 1;
    localparam int unsigned CTRL_IRQ_EN       = 2;
    localparam int unsigned CTRL_COUNT_CLEAR  = 3;
    localparam int unsigned CTRL_ACK          = 4;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;

    localparam int unsigned STATUS_PENDING = 0;
    localparam int unsigned STATUS_RUNNING = 1;

    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    // Replace only the bytes selected by mask.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: CTRL/COMPARE/COUNT/STATUS registers, counter and match logic.
// Optional per-channel prescaler when TIMER_BANK_PRESCALE_EN is defined.
module timer_bank_channel
    import timer_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [3:0]  we,
    input  logic [1:0]  reg_idx,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic             enable_q, enable_d;
    logic             periodic_q, periodic_d;
    logic             irq_en_q, irq_en_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [31:0]      compare_merged, count_merged;
    logic [7:0]       prescale_rd;
    logic             wr_ctrl, ctrl_lo, count_clear, ack;
    logic             div_hit, tick, match;

    assign wr_ctrl     = wr && (reg_idx == REG_CTRL);
    assign ctrl_lo     = wr_ctrl && we[0];
    assign count_clear = wr_ctrl && wdata[CTRL_COUNT_CLEAR];
    assign ack         = wr_ctrl && wdata[CTRL_ACK];

    assign compare_merged = byte_merge(32'(compare_q), wdata, we);
    assign count_merged   = byte_merge(32'(count_q), wdata, we);

`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0] prescale_q, prescale_d;
    logic [7:0] div_q, div_d;

    // >= keeps the divider from running away if P is lowered mid-count.
    assign div_hit     = (div_q >= prescale_q);
    assign prescale_rd = prescale_q;

    always_comb begin
        prescale_d = prescale_q;
        div_d      = div_q;
        if (wr_ctrl && we[1]) prescale_d = wdata[CTRL_PRESCALE_LSB +: 8];
        if (!enable_q || div_hit || count_clear) begin
            div_d = '0;
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '0;
            div_q      <= '0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`else
    assign div_hit     = 1'b1;
    assign prescale_rd = '0;
`endif

    assign tick  = enable_q && div_hit;
    assign match = tick && (count_q == compare_q);

    // Later assignments carry precedence: writes beat the tick, match beats ack.
    always_comb begin
        enable_d   = enable_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        pending_d  = pending_q;
        compare_d  = compare_q;
        count_d    = count_q;

        if (match) begin
            if (periodic_q) count_d = '0;
            else            enable_d = 1'b0;
        end else if (tick) begin
            if (count_q > compare_q) count_d = '0;
            else                     count_d = count_q + WIDTH'(1);
        end

        if (ack)   pending_d = 1'b0;
        if (match) pending_d = 1'b1;

        if (ctrl_lo) begin
            enable_d   = wdata[CTRL_ENABLE];
            periodic_d = wdata[CTRL_PERIODIC];
            irq_en_d   = wdata[CTRL_IRQ_EN];
        end
        if (count_clear) count_d = '0;
        if (wr && (reg_idx == REG_COUNT))   count_d   = count_merged[WIDTH-1:0];
        if (wr && (reg_idx == REG_COMPARE)) compare_d = compare_merged[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q   <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            pending_q  <= 1'b0;
            compare_q  <= COMPARE_RESET[WIDTH-1:0];
            count_q    <= '0;
        end else begin
            enable_q   <= enable_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            pending_q  <= pending_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_idx)
            REG_CTRL: begin
                rdata[CTRL_ENABLE]               = enable_q;
                rdata[CTRL_PERIODIC]             = periodic_q;
                rdata[CTRL_IRQ_EN]               = irq_en_q;
                rdata[CTRL_PRESCALE_LSB +: 8]    = prescale_rd;
            end
            REG_COMPARE: rdata = 32'(compare_q);
            REG_COUNT:   rdata = 32'(count_q);
            REG_STATUS: begin
                rdata[STATUS_PENDING] = pending_q;
                rdata[STATUS_RUNNING] = enable_q;
            end
        endcase
    end

    assign irq = pending_q && irq_en_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel memory-mapped timer: address/write decode, read mux and interrupt OR.
// Build option: TIMER_BANK_PRESCALE_EN adds an 8-bit per-channel prescaler in CTRL[15:8].
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = $clog2(CHANNELS) + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic [3:0]          we,
    input  logic [AW-1:0]       addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CHANNELS-1:0] irq_vec,
    output logic                irq
);

    logic [AW-1:0] ch_sel;
    logic [1:0]    reg_idx;
    logic          wr_any;
    logic [31:0]   ch_rdata [CHANNELS];

    assign ch_sel  = addr >> 2;
    assign reg_idx = addr[1:0];
    assign wr_any  = sel && (we != 4'b0000);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_bank_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr_any && (ch_sel == AW'(i))),
            .we      (we),
            .reg_idx (reg_idx),
            .wdata   (wdata),
            .rdata   (ch_rdata[i]),
            .irq     (irq_vec[i])
        );
    end

    // Channel indices with no instance fall through to zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == AW'(i)) rdata = ch_rdata[i];
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: scoreboard of expected reads and interrupt levels.
module tb_timer_bank;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned AW       = 4;

    logic                clk;
    logic                reset;
    logic                sel;
    logic [3:0]          we;
    logic [AW-1:0]       addr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic [CHANNELS-1:0] irq_vec;
    logic                irq;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    timer_bank #(
        .CHANNELS(CHANNELS),
        .WIDTH   (WIDTH),
        .AW      (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sel     (sel),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_vec (irq_vec),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        check(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] data, input logic [3:0] mask);
        addr  = AW'(ch * 4 + r);
        wdata = data;
        we    = mask;
        sel   = 1'b1;
        @(posedge clk);
        #1;
        sel = 1'b0;
        we  = 4'b0000;
    endtask

    task automatic rd(input string tag, input int ch, input int r, input logic [31:0] exp);
        addr = AW'(ch * 4 + r);
        sel  = 1'b1;
        we   = 4'b0000;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        sb_pop(rdata);
        sel = 1'b0;
    endtask

    task automatic irq_chk(input string tag, input logic [CHANNELS-1:0] exp_vec);
        exp_q.push_back(32'(exp_vec));
        tag_q.push_back({tag, "_vec"});
        exp_q.push_back(32'(|exp_vec));
        tag_q.push_back({tag, "_irq"});
        #1;
        sb_pop(32'(irq_vec));
        sb_pop(32'(irq));
    endtask

    initial begin
        reset = 1'b1;
        sel   = 1'b0;
        we    = 4'b0000;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int ch = 0; ch < 4; ch++) begin
            rd("rst_ctrl", ch, 0, 32'h0);
            rd("rst_compare", ch, 1, 32'hFFFF_FFFF);
            rd("rst_count", ch, 2, 32'h0);
            rd("rst_status", ch, 3, 32'h0);
            irq_chk("rst", 4'b0000);
            cycles(1);
        end

        // Channel 0 periodic, COMPARE=5: six ticks per period.
        wr(0, 1, 32'd5, 4'hF);
        wr(0, 0, 32'h7, 4'hF);
        cycles(5);
        rd("c0_count5", 0, 2, 32'd5);
        rd("c0_running", 0, 3, 32'h2);
        irq_chk("c0_before", 4'b0000);
        cycles(1);
        rd("c0_pending", 0, 3, 32'h3);
        rd("c0_reload", 0, 2, 32'd0);
        irq_chk("c0_match", 4'b0001);
        cycles(3);
        rd("c0_count3", 0, 2, 32'd3);
        cycles(3);
        rd("c0_wrap2", 0, 2, 32'd0);
        rd("c0_sticky", 0, 3, 32'h3);
        wr(0, 0, 32'h17, 4'hF);
        rd("c0_acked", 0, 3, 32'h2);
        rd("c0_after_ack", 0, 2, 32'd1);
        irq_chk("c0_ack", 4'b0000);
        cycles(4);
        rd("c0_pre_collide", 0, 2, 32'd5);
        wr(0, 0, 32'h17, 4'hF);
        rd("c0_collide_st", 0, 3, 32'h3);
        rd("c0_collide_cnt", 0, 2, 32'd0);
        irq_chk("c0_collide", 4'b0001);
        wr(0, 0, 32'h10, 4'hF);
        rd("c0_stopped", 0, 3, 32'h0);
        irq_chk("c0_stop", 4'b0000);

        // Channel 1 one-shot, COMPARE=3.
        wr(1, 1, 32'd3, 4'hF);
        wr(1, 0, 32'h5, 4'hF);
        cycles(3);
        rd("c1_count3", 1, 2, 32'd3);
        rd("c1_running", 1, 3, 32'h2);
        irq_chk("c1_before", 4'b0000);
        cycles(1);
        rd("c1_autostop", 1, 3, 32'h1);
        rd("c1_hold", 1, 2, 32'd3);
        irq_chk("c1_match", 4'b0010);
        wr(1, 0, 32'h14, 4'hF);
        rd("c1_acked", 1, 3, 32'h0);
        irq_chk("c1_ack", 4'b0000);
        cycles(10);
        rd("c1_idle_st", 1, 3, 32'h0);
        rd("c1_idle_cnt", 1, 2, 32'd3);
        irq_chk("c1_idle", 4'b0000);

        // Channel 2: COMPARE lowered beneath a running count.
        wr(2, 2, 32'd100, 4'hF);
        wr(2, 0, 32'h5, 4'hF);
        wr(2, 1, 32'd10, 4'hF);
        rd("c2_count101", 2, 2, 32'd101);
        cycles(1);
        rd("c2_overrun", 2, 2, 32'd0);
        rd("c2_no_pend", 2, 3, 32'h2);
        irq_chk("c2_overrun", 4'b0000);
        cycles(10);
        rd("c2_count10", 2, 2, 32'd10);
        cycles(1);
        rd("c2_match_st", 2, 3, 32'h1);
        rd("c2_match_cnt", 2, 2, 32'd10);
        irq_chk("c2_match", 4'b0100);
        wr(2, 2, 32'h1234_5678, 4'hF);
        wr(2, 2, 32'hAABB_CCEE, 4'b0001);
        rd("c2_count_byte0", 2, 2, 32'h1234_56EE);
        wr(2, 1, 32'hFFFF_FFFF, 4'b0100);
        rd("c2_compare_byte2", 2, 1, 32'h00FF_000A);
        wr(2, 0, 32'h10, 4'hF);
        irq_chk("c2_ack", 4'b0000);

        // Channel 3: CTRL[15:8] prescale field.
        wr(3, 0, 32'h0000_AB00, 4'hF);
`ifdef TIMER_BANK_PRESCALE_EN
        rd("c3_prescale_rd", 3, 0, 32'h0000_AB00);
        wr(3, 1, 32'd2, 4'hF);
        wr(3, 0, 32'h0307, 4'hF);
        cycles(11);
        rd("c3_pre_cnt", 3, 2, 32'd2);
        rd("c3_pre_st", 3, 3, 32'h2);
        cycles(1);
        rd("c3_match1", 3, 3, 32'h3);
        irq_chk("c3_match1", 4'b1000);
        wr(3, 0, 32'h0317, 4'hF);
        rd("c3_acked", 3, 3, 32'h2);
        cycles(10);
        rd("c3_pre_match2", 3, 3, 32'h2);
        cycles(1);
        rd("c3_match2", 3, 3, 32'h3);
        wr(3, 0, 32'h10, 4'hF);
        irq_chk("c3_stop", 4'b0000);
`else
        rd("c3_prescale_rd", 3, 0, 32'h0);
`endif

        // Asynchronous reset in the middle of a running count.
        wr(0, 0, 32'h7, 4'hF);
        cycles(3);
        reset = 1'b1;
        #1;
        rd("mid_rst_ctrl", 0, 0, 32'h0);
        rd("mid_rst_count", 0, 2, 32'h0);
        rd("mid_rst_compare", 2, 1, 32'hFFFF_FFFF);
        rd("mid_rst_status", 1, 3, 32'h0);
        irq_chk("mid_rst", 4'b0000);
        reset = 1'b0;
        cycles(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
